dac_ddr_framer: RTL and testbench

Parametrised, vendor-neutral DDR sample framer for dual-channel (I/Q interleaved) parallel-LVDS DACs. It packs per-bus I/Q samples into rise/fall words for external ODDR/OBUFDS cells and generates the DCI pattern. It adds built-in test patterns, two's-complement to offset-binary conversion, underflow hold/mute and an underflow counter. It sits between the DSP sample stream and the board-level pin wrapper, clocked by the buffered DAC DCO clock.

---
 rtl/dac_ddr_pkg.sv | 26 ++
 rtl/dac_ddr_lane.sv | 43 ++++
 rtl/dac_ddr_framer.sv | 148 ++++++++++++++
 tb/tb_dac_ddr_framer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_ddr_pkg.sv
// rtl/dac_ddr_pkg.sv - shared mode encoding and code-point helpers for the DAC DDR framer
package dac_ddr_pkg;

  typedef enum logic [2:0] {
    MODE_NORMAL = 3'd0,
    MODE_MID    = 3'd1,
    MODE_RAMP   = 3'd2,
    MODE_ALT    = 3'd3,
    MODE_CONST  = 3'd4
  } mode_e;

  // Also the XOR mask that turns two's complement into offset binary.
  function automatic logic [31:0] midcode(input int dw, input int offset_bin);
    return (offset_bin != 0) ? (32'd1 << (dw - 1)) : 32'd0;
  endfunction

  function automatic logic [31:0] alt_pattern(input int dw);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < dw; i++) begin
      if (((dw - 1 - i) % 2) == 0) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/dac_ddr_lane.sv
// rtl/dac_ddr_lane.sv - per-bus output stage: format conversion, pin-swap flip, output register
module dac_ddr_lane
  import dac_ddr_pkg::*;
#(
  parameter int            DW         = 14,
  parameter int            OFFSET_BIN = 1,
  parameter logic [DW-1:0] FLIP       = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] rise_in,
  input  logic [DW-1:0] fall_in,
  input  logic          conv,
  output logic [DW-1:0] d_rise,
  output logic [DW-1:0] d_fall
);

  localparam logic [DW-1:0] CONV_MASK = DW'(midcode(DW, OFFSET_BIN));
  localparam logic [DW-1:0] RST_VAL   = CONV_MASK ^ FLIP;

  logic [DW-1:0] d_rise_d, d_rise_q;
  logic [DW-1:0] d_fall_d, d_fall_q;

  // Test patterns arrive with conv low and bypass conversion; the flip always applies.
  always_comb begin
    d_rise_d = (conv ? (rise_in ^ CONV_MASK) : rise_in) ^ FLIP;
    d_fall_d = (conv ? (fall_in ^ CONV_MASK) : fall_in) ^ FLIP;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_rise_q <= RST_VAL;
      d_fall_q <= RST_VAL;
    end else begin
      d_rise_q <= d_rise_d;
      d_fall_q <= d_fall_d;
    end
  end

  assign d_rise = d_rise_q;
  assign d_fall = d_fall_q;

endmodule

// File: rtl/dac_ddr_framer.sv
// rtl/dac_ddr_framer.sv - I/Q DDR sample framer: mode mux, ramp, underflow hold/mute, per-bus lanes
module dac_ddr_framer
  import dac_ddr_pkg::*;
#(
  parameter int                 DW         = 14,
  parameter int                 NBUS       = 1,
  parameter int                 OFFSET_BIN = 1,
  parameter logic [NBUS*DW-1:0] FLIP_D     = '0,
  parameter logic               FLIP_DCI   = 1'b0,
  parameter int                 MUTE_AFTER = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NBUS*DW-1:0] data_i,
  input  logic [NBUS*DW-1:0] data_q,
  input  logic               data_valid,
  input  logic [2:0]         mode,
  input  logic [DW-1:0]      const_val,
  input  logic [DW-1:0]      ramp_step,
  input  logic               clr_cnt,
  output logic [NBUS*DW-1:0] d_rise,
  output logic [NBUS*DW-1:0] d_fall,
  output logic               dci_rise,
  output logic               dci_fall,
  output logic               muted,
  output logic [15:0]        underflow_cnt
);

  localparam logic [15:0]   MUTE_TH = 16'(MUTE_AFTER);
  localparam logic [DW-1:0] ALT     = DW'(alt_pattern(DW));

  logic [2:0]         mode_prev_d, mode_prev_q;
  logic [DW-1:0]      acc_d, acc_q;
  logic [15:0]        run_d, run_q;
  logic               muted_d, muted_q;
  logic [15:0]        ucnt_d, ucnt_q;
  logic [NBUS*DW-1:0] hold_i_d, hold_i_q;
  logic [NBUS*DW-1:0] hold_q_d, hold_q_q;
  logic [NBUS*DW-1:0] s1_rise_d, s1_rise_q;
  logic [NBUS*DW-1:0] s1_fall_d, s1_fall_q;
  logic               s1_conv_d, s1_conv_q;
  logic [DW-1:0]      ramp_base;
  logic [DW-1:0]      ramp_fall;

  // Stage-1 words stay in the input domain when conv is set; zero there means midscale.
  always_comb begin
    mode_prev_d = mode;
    acc_d       = acc_q;
    run_d       = '0;
    muted_d     = 1'b0;
    ucnt_d      = ucnt_q;
    hold_i_d    = hold_i_q;
    hold_q_d    = hold_q_q;
    s1_rise_d   = '0;
    s1_fall_d   = '0;
    s1_conv_d   = 1'b1;
    ramp_base   = (mode_prev_q != MODE_RAMP) ? '0 : acc_q;
    ramp_fall   = ramp_base + ramp_step;

    case (mode)
      MODE_NORMAL: begin
        if (data_valid) begin
          hold_i_d  = data_i;
          hold_q_d  = data_q;
          s1_rise_d = data_i;
          s1_fall_d = data_q;
        end else begin
          run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
          if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
          if (run_d >= MUTE_TH) begin
            muted_d = 1'b1;
          end else begin
            s1_rise_d = hold_i_q;
            s1_fall_d = hold_q_q;
          end
        end
      end
      MODE_RAMP: begin
        s1_rise_d = {NBUS{ramp_base}};
        s1_fall_d = {NBUS{ramp_fall}};
        s1_conv_d = 1'b0;
        acc_d     = ramp_fall + ramp_step;
      end
      MODE_ALT: begin
        s1_rise_d = {NBUS{ALT}};
        s1_fall_d = {NBUS{~ALT}};
        s1_conv_d = 1'b0;
      end
      MODE_CONST: begin
        s1_rise_d = {NBUS{const_val}};
        s1_fall_d = {NBUS{const_val}};
        s1_conv_d = 1'b0;
      end
      default: begin
      end
    endcase

    if (clr_cnt) ucnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_prev_q <= '0;
      acc_q       <= '0;
      run_q       <= '0;
      muted_q     <= 1'b0;
      ucnt_q      <= '0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      s1_rise_q   <= '0;
      s1_fall_q   <= '0;
      s1_conv_q   <= 1'b1;
    end else begin
      mode_prev_q <= mode_prev_d;
      acc_q       <= acc_d;
      run_q       <= run_d;
      muted_q     <= muted_d;
      ucnt_q      <= ucnt_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
      s1_rise_q   <= s1_rise_d;
      s1_fall_q   <= s1_fall_d;
      s1_conv_q   <= s1_conv_d;
    end
  end

  for (genvar b = 0; b < NBUS; b++) begin : g_lane
    dac_ddr_lane #(
      .DW        (DW),
      .OFFSET_BIN(OFFSET_BIN),
      .FLIP      (FLIP_D[b*DW +: DW])
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .rise_in(s1_rise_q[b*DW +: DW]),
      .fall_in(s1_fall_q[b*DW +: DW]),
      .conv   (s1_conv_q),
      .d_rise (d_rise[b*DW +: DW]),
      .d_fall (d_fall[b*DW +: DW])
    );
  end

  assign dci_rise      = FLIP_DCI;
  assign dci_fall      = ~FLIP_DCI;
  assign muted         = muted_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_dac_ddr_framer.sv
// tb/tb_dac_ddr_framer.sv - directed bench for dac_ddr_framer with hand-computed expectations
module tb_dac_ddr_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] data_i, data_q;
  logic [27:0] data2_i, data2_q;
  logic        data_valid;
  logic [2:0]  mode;
  logic [13:0] const_val, ramp_step;
  logic        clr_cnt;

  logic [13:0] r0, f0, r1, f1;
  logic [27:0] r2, f2;
  logic        dr0, df0, dr1, df1, dr2, df2;
  logic        m0, m1, m2;
  logic [15:0] c0, c1, c2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dac_ddr_framer #(.DW(14), .NBUS(1), .OFFSET_BIN(1), .FLIP_D(14'h0000), .FLIP_DCI(1'b0),
                   .MUTE_AFTER(4)) u0 (
    .clk(clk), .reset_n(reset_n), .data_i(data_i), .data_q(data_q), .data_valid(data_valid),
    .mode(mode), .const_val(const_val), .ramp_step(ramp_step), .clr_cnt(clr_cnt),
    .d_rise(r0), .d_fall(f0), .dci_rise(dr0), .dci_fall(df0), .muted(m0), .underflow_cnt(c0));

  dac_ddr_framer #(.DW(14), .NBUS(1), .OFFSET_BIN(1), .FLIP_D(14'h0001), .FLIP_DCI(1'b1),
                   .MUTE_AFTER(16)) u1 (
    .clk(clk), .reset_n(reset_n), .data_i(data_i), .data_q(data_q), .data_valid(data_valid),
    .mode(mode), .const_val(const_val), .ramp_step(ramp_step), .clr_cnt(clr_cnt),
    .d_rise(r1), .d_fall(f1), .dci_rise(dr1), .dci_fall(df1), .muted(m1), .underflow_cnt(c1));

  dac_ddr_framer #(.DW(14), .NBUS(2), .OFFSET_BIN(1), .FLIP_D(28'hFFFC000), .FLIP_DCI(1'b0),
                   .MUTE_AFTER(4)) u2 (
    .clk(clk), .reset_n(reset_n), .data_i(data2_i), .data_q(data2_q), .data_valid(data_valid),
    .mode(mode), .const_val(const_val), .ramp_step(ramp_step), .clr_cnt(clr_cnt),
    .d_rise(r2), .d_fall(f2), .dci_rise(dr2), .dci_fall(df2), .muted(m2), .underflow_cnt(c2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    data_i     = '0;
    data_q     = '0;
    data2_i    = '0;
    data2_q    = '0;
    data_valid = 1'b0;
    mode       = 3'd0;
    const_val  = '0;
    ramp_step  = '0;
    clr_cnt    = 1'b0;
    repeat (3) tick();

    chk("rst_rise", r0, 32'h2000);
    chk("rst_fall", f0, 32'h2000);
    chk("rst_dci_rise", dr0, 32'h0);
    chk("rst_dci_fall", df0, 32'h1);
    chk("rst_cnt", c0, 32'h0);
    chk("rst_muted", m0, 32'h0);
    chk("rst_flip_rise", r1, 32'h2001);
    chk("rst_flipdci_rise", dr1, 32'h1);
    chk("rst_flipdci_fall", df1, 32'h0);
    chk("rst_bus1_rise", r2[27:14], 32'h1FFF);

    // Normal mode: extreme codes and two distinct buses
    reset_n    = 1'b1;
    data_valid = 1'b1;
    data_i     = 14'h1FFF;
    data_q     = 14'h2000;
    data2_i    = {14'h1000, 14'h0123};
    data2_q    = {14'h3F00, 14'h0456};
    tick();
    tick();
    chk("norm_rise", r0, 32'h3FFF);
    chk("norm_fall", f0, 32'h0000);
    chk("b0_rise", r2[13:0], 32'h2123);
    chk("b0_fall", f2[13:0], 32'h2456);
    chk("b1_rise", r2[27:14], 32'h0FFF);
    chk("b1_fall", f2[27:14], 32'h20FF);

    // Underflow hold then mute
    data_i = 14'h0100;
    data_q = 14'h0100;
    tick();
    data_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("uf_rise_%0d", k), r0, (k <= 4) ? 32'h2100 : 32'h2000);
      chk($sformatf("uf_fall_%0d", k), f0, (k <= 4) ? 32'h2100 : 32'h2000);
      chk($sformatf("uf_muted_%0d", k), m0, (k >= 4) ? 32'h1 : 32'h0);
      chk($sformatf("uf_cnt_%0d", k), c0, k);
    end
    data_valid = 1'b1;
    data_i     = 14'h0055;
    data_q     = 14'h0055;
    tick();
    chk("unmute_muted", m0, 32'h0);
    chk("unmute_cnt", c0, 32'h6);
    tick();
    chk("unmute_rise", r0, 32'h2055);
    data_valid = 1'b0;
    clr_cnt    = 1'b1;
    tick();
    chk("clr_wins", c0, 32'h0);
    clr_cnt    = 1'b0;
    data_valid = 1'b1;

    // Ramp step 1, entered from normal mode, no counting while invalid
    mode       = 3'd2;
    ramp_step  = 14'h0001;
    data_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ramp_rise_%0d", k), r0, 2 * k);
      chk($sformatf("ramp_fall_%0d", k), f0, 2 * k + 1);
    end
    chk("ramp_cnt_hold", c0, 32'h0);
    chk("ramp_muted", m0, 32'h0);

    // Constant and alternating patterns, raw plus flip
    mode      = 3'd4;
    const_val = 14'h0123;
    tick();
    tick();
    chk("const_rise", r0, 32'h0123);
    chk("const_flip_rise", r1, 32'h0122);
    chk("const_flip_fall", f1, 32'h0122);
    mode = 3'd3;
    tick();
    tick();
    chk("alt_rise", r0, 32'h2AAA);
    chk("alt_fall", f0, 32'h1555);
    chk("alt_flip_rise", r1, 32'h2AAB);
    chk("alt_flip_fall", f1, 32'h1554);

    // Ramp wrap: re-entry resets acc, a one-cycle step of 0x1FFE lands acc on 0x3FFE
    mode      = 3'd2;
    ramp_step = 14'h0001;
    tick();
    ramp_step = 14'h1FFE;
    tick();
    chk("reentry_rise", r0, 32'h0000);
    chk("reentry_fall", f0, 32'h0001);
    ramp_step = 14'h0001;
    tick();
    chk("jump_fall", f0, 32'h2000);
    tick();
    chk("wrap_pre_rise", r0, 32'h3FFE);
    chk("wrap_pre_fall", f0, 32'h3FFF);
    tick();
    chk("wrap_rise", r0, 32'h0000);
    chk("wrap_fall", f0, 32'h0001);

    // One-cycle reset pulse mid-ramp
    reset_n = 1'b0;
    tick();
    chk("pulse_rise", r0, 32'h2000);
    chk("pulse_fall", f0, 32'h2000);
    reset_n = 1'b1;
    tick();
    chk("pulse_after_rise", r0, 32'h2000);
    tick();
    chk("restart_rise0", r0, 32'h0000);
    chk("restart_fall0", f0, 32'h0001);
    tick();
    chk("restart_rise1", r0, 32'h0002);
    chk("restart_fall1", f0, 32'h0003);

    // Mode 6 aliases midscale on every bus
    mode = 3'd6;
    tick();
    tick();
    chk("m6_rise", r0, 32'h2000);
    chk("m6_b0_rise", r2[13:0], 32'h2000);
    chk("m6_b0_fall", f2[13:0], 32'h2000);
    chk("m6_b1_rise", r2[27:14], 32'h1FFF);
    chk("m6_b1_fall", f2[27:14], 32'h1FFF);
    chk("m6_cnt", c0, 32'h0);

    // Counter saturation
    mode = 3'd0;
    repeat (65540) tick();
    chk("sat_cnt", c0, 32'hFFFF);
    chk("sat_muted", m0, 32'h1);
    chk("sat_out", r0, 32'h2000);
    clr_cnt = 1'b1;
    tick();
    chk("sat_clr", c0, 32'h0);
    clr_cnt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
